// File: rtl/neo_pkg.sv
// Shared types and helpers for the NEO sample reader.
//   rd_state_t   : reader FSM states
//   READ_LATENCY : Memory read latency in cycles (raddr -> rdata)
//   addr_w(m)    : read-address width for an m-entry Memory
package neo_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_DONE} rd_state_t;

  localparam int READ_LATENCY = 1;

  function automatic int addr_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/neo_sample_fifo.sv
// Small FIFO buffering Memory read data for the window shifter.
// Ports:
//   Clk, reset        : clock, async active-low reset
//   i_push / i_din    : write one sample
//   i_pop             : drop the head sample (head is valid when count != 0)
//   o_head            : current head sample
//   o_count           : number of samples held
module neo_sample_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic signed [N-1:0]          i_din,
  output logic signed [N-1:0]          o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic signed [N-1:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wp;
  logic [PW-1:0]       r_rp;
  logic [CW-1:0]       r_cnt;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      end
      if (i_pop)
        r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

  // The reader's credit rule should make both of these unreachable.
  a_no_overflow: assert property (@(posedge Clk) disable iff (!reset)
    !(i_push && !i_pop && r_cnt == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge Clk) disable iff (!reset)
    !(i_pop && r_cnt == '0));

endmodule

// File: rtl/neo_sample_reader.sv
// Read-side master for the sample Memory. On start, reads locations 0..M-1
// and presents a sliding (x[n-1], x[n], x[n+1]) window, n = 1..M-2, to the
// NEO datapath over valid/ready.
// Ports:
//   Clk, reset             : clock, async active-low reset
//   start                  : begin one pass (ignored while busy)
//   raddr / rdata          : Memory read port (rdata one cycle after raddr)
//   win_prev/cur/next      : window samples, passed through unmodified
//   win_valid / win_ready  : window handshake
//   busy                   : pass in progress (STREAM or DONE)
//   done                   : one-cycle pulse after the last window is taken
module neo_sample_reader
  import neo_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 16
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [addr_w(M)-1:0]     raddr,
  input  logic signed [N-1:0]      rdata,
  output logic signed [N-1:0]      win_prev,
  output logic signed [N-1:0]      win_cur,
  output logic signed [N-1:0]      win_next,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int            AW       = addr_w(M);
  localparam logic [AW-1:0] M_L      = AW'(M);
  localparam logic [AW-1:0] WIN_LAST = AW'(M - 3);

  generate
    if (M < 3) begin : g_bad_m
      $error("neo_sample_reader: M must be at least 3");
    end
  endgenerate

  rd_state_t           r_state, w_state_nxt;
  logic [AW-1:0]       r_rd_cnt;
  logic [AW-1:0]       r_win_cnt;
  logic [AW-1:0]       r_raddr;
  logic                r_inflight;
  logic [1:0]          r_fill;
  logic                r_valid;
  logic signed [N-1:0] r_prev, r_cur, r_next;

  logic                w_issue, w_pop, w_push, w_hs, w_last;
  logic [2:0]          w_used;
  logic signed [N-1:0] w_head;
  logic [1:0]          w_fcnt;

  // Read data lands exactly one cycle after the issue cycle, so the
  // in-flight flag doubles as the FIFO push strobe.
  assign w_push = r_inflight;
  assign w_hs   = r_valid & win_ready;

  neo_sample_fifo #(.N(N), .DEPTH(2)) u_fifo (
    .Clk     (Clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (rdata),
    .o_head  (w_head),
    .o_count (w_fcnt)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_state <= RD_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_pop       = 1'b0;
    w_last      = 1'b0;
    w_used      = '0;
    case (r_state)
      RD_IDLE: if (start) w_state_nxt = RD_STREAM;
      RD_STREAM: begin
        w_last = w_hs && (r_win_cnt == WIN_LAST);
        // Pop while filling, while waiting to re-present a shifted window,
        // or to shift on a handshake that is not the final one.
        w_pop  = (w_fcnt != 2'd0) &&
                 ((r_fill != 2'd3) || !r_valid || (w_hs && !w_last));
        // Credits count the slot freed by a same-cycle pop; without this a
        // single outstanding read could only sustain one window per 2 cycles.
        w_used  = {1'b0, w_fcnt} - {2'b0, w_pop} + {2'b0, r_inflight};
        w_issue = (r_rd_cnt < M_L) && (w_used < 3'd2);
        if (w_last) w_state_nxt = RD_DONE;
      end
      RD_DONE: w_state_nxt = RD_IDLE;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_rd_cnt   <= '0;
      r_win_cnt  <= '0;
      r_raddr    <= '0;
      r_inflight <= 1'b0;
      r_fill     <= '0;
      r_valid    <= 1'b0;
      r_prev     <= '0;
      r_cur      <= '0;
      r_next     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == RD_IDLE) begin
        r_rd_cnt  <= '0;
        r_win_cnt <= '0;
        r_fill    <= '0;
      end
      if (w_issue) begin
        r_raddr  <= r_rd_cnt;
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      // The first three pops fill the window through the same shift path.
      if (w_pop) begin
        r_prev <= r_cur;
        r_cur  <= r_next;
        r_next <= w_head;
        if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      end
      if (w_pop && r_fill[1])  r_valid <= 1'b1;
      else if (w_hs)           r_valid <= 1'b0;
      if (w_hs) r_win_cnt <= r_win_cnt + 1'b1;
    end
  end

  // raddr is presented in the issue cycle and otherwise holds the last address.
  assign raddr     = w_issue ? r_rd_cnt : r_raddr;
  assign win_prev  = r_prev;
  assign win_cur   = r_cur;
  assign win_next  = r_next;
  assign win_valid = r_valid;
  assign busy      = (r_state != RD_IDLE);
  assign done      = (r_state == RD_DONE);

endmodule
